// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver: start(1) + WIDTH data bits MSB-first + stop(0), one bit per s_en strobe,
// deserialized into a one-deep valid/ready buffer with flagged and counted framing/overrun errors.
//   state   | meaning
//   IDLE    | hunting for a start bit
//   DATA    | shifting in data bits, down-counter at 0 marks the last one
//   STOP    | checking the stop bit, then hand off, drop or flag
module sipo_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_en,
    input  logic                 s_in,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 frm_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]     r_shreg, w_shreg_nxt;
    logic [WIDTH-1:0]     r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frm_err;
    logic                 r_overrun;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_load;
    logic                 w_ferr;
    logic                 w_ovr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        w_ovr       = 1'b0;
        if (s_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (s_in) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = LAST_BIT;
                    end
                end
                ST_DATA: begin
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], s_in};
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    // A consume on this same cycle frees the buffer for the new word.
                    if (s_in) begin
                        w_ferr = 1'b1;
                    end else if (!r_valid || m_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_ovr = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_frm_err <= w_ferr;
            r_overrun <= w_ovr;
            if (w_load) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end
            if ((w_ferr || w_ovr) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign m_data  = r_data;
    assign m_valid = r_valid;
    assign busy    = r_busy;
    assign frm_err = r_frm_err;
    assign overrun = r_overrun;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver (WIDTH=4, ERR_CNT_W=8) with hand-computed expectations.
module tb_sipo_frame_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_en = 1'b0;
    logic       s_in = 1'b0;
    logic       m_ready = 1'b0;
    logic [3:0] m_data;
    logic       m_valid;
    logic       busy;
    logic       frm_err;
    logic       overrun;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    sipo_frame_receiver #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_en    (s_en),
        .s_in    (s_in),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy),
        .frm_err (frm_err),
        .overrun (overrun),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One strobed bit; returns 1 time unit after the sampling edge.
    task automatic strobe(input logic b, input int gap, input logic rdy);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        s_en    = 1'b1;
        s_in    = b;
        m_ready = rdy;
        @(posedge clk);
        #1;
        s_en    = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] w, input logic stop, input int gap, input logic rdy_stop);
        strobe(1'b1, gap, 1'b0);
        for (int i = 3; i >= 0; i--) strobe(w[i], gap, 1'b0);
        strobe(stop, gap, rdy_stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic consume();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        s_in = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst  = 1'b1;
        s_in = 1'b0;
    endtask

    initial begin
        // reset with random serial input
        do_reset();
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_frm_err", 32'(frm_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);

        // single frame 1010, held until consumed
        strobe(1'b1, 0, 1'b0);
        chk("start_busy", 32'(busy), 32'h1);
        strobe(1'b1, 0, 1'b0);
        strobe(1'b0, 0, 1'b0);
        strobe(1'b1, 0, 1'b0);
        strobe(1'b0, 0, 1'b0);
        chk("pre_stop_valid", 32'(m_valid), 32'h0);
        strobe(1'b0, 0, 1'b0);
        chk("single_valid", 32'(m_valid), 32'h1);
        chk("single_data", 32'(m_data), 32'hA);
        chk("single_busy", 32'(busy), 32'h0);
        idle(3);
        chk("hold_valid", 32'(m_valid), 32'h1);
        chk("hold_data", 32'(m_data), 32'hA);
        consume();
        chk("consumed_valid", 32'(m_valid), 32'h0);

        // framing error: data 0110, stop=1
        send_frame(4'h6, 1'b1, 0, 1'b0);
        chk("ferr_pulse", 32'(frm_err), 32'h1);
        chk("ferr_cnt", 32'(err_cnt), 32'h1);
        chk("ferr_valid", 32'(m_valid), 32'h0);
        chk("ferr_no_ovr", 32'(overrun), 32'h0);
        idle(1);
        chk("ferr_pulse_end", 32'(frm_err), 32'h0);

        // overrun: A then 5 with nobody consuming
        do_reset();
        send_frame(4'hA, 1'b0, 0, 1'b0);
        chk("ovr_first_valid", 32'(m_valid), 32'h1);
        send_frame(4'h5, 1'b0, 0, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'h1);
        chk("ovr_data_kept", 32'(m_data), 32'hA);
        chk("ovr_valid", 32'(m_valid), 32'h1);
        chk("ovr_cnt", 32'(err_cnt), 32'h1);
        chk("ovr_no_ferr", 32'(frm_err), 32'h0);
        idle(1);
        chk("ovr_pulse_end", 32'(overrun), 32'h0);

        // consume coincident with second stop bit
        consume();
        chk("sim_pre_valid", 32'(m_valid), 32'h0);
        send_frame(4'hA, 1'b0, 0, 1'b0);
        send_frame(4'h5, 1'b0, 0, 1'b1);
        chk("sim_data", 32'(m_data), 32'h5);
        chk("sim_valid", 32'(m_valid), 32'h1);
        chk("sim_no_ovr", 32'(overrun), 32'h0);
        chk("sim_cnt", 32'(err_cnt), 32'h1);
        consume();

        // sparse strobes, one in three cycles
        send_frame(4'h3, 1'b0, 2, 1'b0);
        chk("gap_data", 32'(m_data), 32'h3);
        chk("gap_valid", 32'(m_valid), 32'h1);
        consume();

        // reset after two data bits of a frame, then a clean 4'hC frame
        strobe(1'b1, 0, 1'b0);
        strobe(1'b1, 0, 1'b0);
        strobe(1'b1, 0, 1'b0);
        chk("mid_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_valid", 32'(m_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(4'hC, 1'b0, 0, 1'b0);
        chk("after_rst_data", 32'(m_data), 32'hC);
        chk("after_rst_valid", 32'(m_valid), 32'h1);
        chk("after_rst_cnt", 32'(err_cnt), 32'h0);
        consume();

        // saturation of the error counter
        for (int i = 0; i < 255; i++) send_frame(4'h9, 1'b1, 0, 1'b0);
        chk("sat_255", 32'(err_cnt), 32'hFF);
        for (int i = 0; i < 45; i++) send_frame(4'h9, 1'b1, 0, 1'b0);
        chk("sat_pulse", 32'(frm_err), 32'h1);
        chk("sat_300", 32'(err_cnt), 32'hFF);
        chk("sat_valid", 32'(m_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
